// File: rtl/ysyx_220053_dbus_bridge.sv
// Data-side bus bridge: one 128-bit line request becomes a 2-beat INCR burst on the 64-bit memory bus.
// A single transaction is in flight at a time; the result is returned with a one-cycle ready pulse.
//
// state   | meaning
// IDLE    | waiting for d_rw_valid_i; latches address, write line and clears the error flag
// RD_ADDR | ar_valid_o high until ar_ready_i
// RD_DATA | r_ready_o high; collects BEATS read beats
// WR_ADDR | aw_valid_o high until aw_ready_i
// WR_DATA | w_valid_o high; sends BEATS write beats
// WR_RESP | b_ready_o high until b_valid_i
// DONE    | d_rw_ready_o pulse with d_rw_err_o; back to IDLE
module ysyx_220053_dbus_bridge #(
  parameter int ADDR_W = 64,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        d_rw_addr_i,
  input  logic                     d_rw_req_i,
  input  logic                     d_rw_valid_i,
  input  logic [BEAT_W*BEATS-1:0]  d_rw_w_data_i,
  output logic [BEAT_W*BEATS-1:0]  d_data_read_o,
  output logic                     d_rw_ready_o,
  output logic                     d_rw_err_o,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  output logic [ADDR_W-1:0]        ar_addr_o,
  output logic [7:0]               ar_len_o,
  output logic [2:0]               ar_size_o,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  input  logic [BEAT_W-1:0]        r_data_i,
  input  logic [1:0]               r_resp_i,
  input  logic                     r_last_i,
  output logic                     aw_valid_o,
  input  logic                     aw_ready_i,
  output logic [ADDR_W-1:0]        aw_addr_o,
  output logic [7:0]               aw_len_o,
  output logic [2:0]               aw_size_o,
  output logic                     w_valid_o,
  input  logic                     w_ready_i,
  output logic [BEAT_W-1:0]        w_data_o,
  output logic [BEAT_W/8-1:0]      w_strb_o,
  output logic                     w_last_o,
  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic [1:0]               b_resp_i
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rline_q;
  logic [LINE_W-1:0] data_q;
  logic              err_q;
  logic [LINE_W-1:0] rline_next;
  logic              last_beat;
  logic              r_bad;

  assign last_beat = (cnt == CNT_LAST);
  // r_last_i only feeds the error flag; the burst length is fixed by the counter.
  assign r_bad = (r_resp_i != 2'b00) || (r_last_i != last_beat);

  always_comb begin
    rline_next = rline_q;
    rline_next[cnt*BEAT_W +: BEAT_W] = r_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_rw_valid_i) begin
            addr_q  <= d_rw_addr_i;
            wline_q <= d_rw_w_data_i;
            err_q   <= 1'b0;
            cnt     <= '0;
            state   <= d_rw_req_i ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (ar_ready_i) state <= RD_DATA;
        end
        RD_DATA: begin
          if (r_valid_i) begin
            rline_q <= rline_next;
            if (r_bad) err_q <= 1'b1;
            if (last_beat) begin
              data_q <= rline_next;
              cnt    <= '0;
              state  <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (aw_ready_i) begin
            cnt   <= '0;
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_ready_i) begin
            if (last_beat) begin
              cnt   <= '0;
              state <= WR_RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (b_valid_i) begin
            if (b_resp_i != 2'b00) err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign d_data_read_o = data_q;
  assign d_rw_ready_o  = (state == DONE);
  assign d_rw_err_o    = err_q;

  assign ar_valid_o = (state == RD_ADDR);
  assign ar_addr_o  = addr_q & LINE_MASK;
  assign ar_len_o   = 8'(BEATS - 1);
  assign ar_size_o  = 3'($clog2(BEAT_W / 8));
  assign r_ready_o  = (state == RD_DATA);

  assign aw_valid_o = (state == WR_ADDR);
  assign aw_addr_o  = addr_q & LINE_MASK;
  assign aw_len_o   = 8'(BEATS - 1);
  assign aw_size_o  = 3'($clog2(BEAT_W / 8));
  assign w_valid_o  = (state == WR_DATA);
  assign w_data_o   = wline_q[cnt*BEAT_W +: BEAT_W];
  assign w_strb_o   = '1;
  assign w_last_o   = (state == WR_DATA) && last_beat;
  assign b_ready_o  = (state == WR_RESP);

endmodule

// File: tb/tb_ysyx_220053_dbus_bridge.sv
// Directed bench for the dbus bridge: stimulus tasks act as memory-unit and bus slave,
// pushing expected completions into a scoreboard popped by a monitor on every ready pulse.
module tb_ysyx_220053_dbus_bridge;

  logic         clk;
  logic         rst;
  logic [63:0]  d_rw_addr_i;
  logic         d_rw_req_i;
  logic         d_rw_valid_i;
  logic [127:0] d_rw_w_data_i;
  logic [127:0] d_data_read_o;
  logic         d_rw_ready_o;
  logic         d_rw_err_o;
  logic         ar_valid_o, ar_ready_i;
  logic [63:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic         r_valid_i, r_ready_o;
  logic [63:0]  r_data_i;
  logic [1:0]   r_resp_i;
  logic         r_last_i;
  logic         aw_valid_o, aw_ready_i;
  logic [63:0]  aw_addr_o;
  logic [7:0]   aw_len_o;
  logic [2:0]   aw_size_o;
  logic         w_valid_o, w_ready_i;
  logic [63:0]  w_data_o;
  logic [7:0]   w_strb_o;
  logic         w_last_o;
  logic         b_valid_i, b_ready_o;
  logic [1:0]   b_resp_i;

  ysyx_220053_dbus_bridge dut (
    .clk(clk), .rst(rst),
    .d_rw_addr_i(d_rw_addr_i), .d_rw_req_i(d_rw_req_i), .d_rw_valid_i(d_rw_valid_i),
    .d_rw_w_data_i(d_rw_w_data_i), .d_data_read_o(d_data_read_o),
    .d_rw_ready_o(d_rw_ready_o), .d_rw_err_o(d_rw_err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i)
  );

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] exp_rd_line = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every completion pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (d_rw_ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got ready=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", d_data_read_o, e.data);
        chk("err", {127'd0, d_rw_err_o}, {127'd0, e.err});
        chk("latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_for(input string name, ref logic sig, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig !== 1'b1 && n < 20);
    if (sig !== 1'b1) begin
      $display("FAIL %s_timeout: got no valid expected valid within 20 cycles", name);
      n_fail++;
      $fatal(1, "bounded wait expired");
    end
    chk({name, "_delay"}, 128'(n), 128'(exp_n));
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [1:0] resp0, input logic [1:0] resp1,
                         input logic last0, input logic last1, input logic exp_err,
                         input int ar_stall, input int extra, input bit hold,
                         input logic [63:0] next_addr);
    exp_t e;
    exp_rd_line = {b1, b0};
    e.data = {b1, b0};
    e.err  = exp_err;
    e.cyc  = cyc + 4 + ar_stall + extra;
    sb.push_back(e);
    d_rw_addr_i  = addr;
    d_rw_req_i   = 1'b0;
    d_rw_valid_i = 1'b1;
    wait_for("ar", ar_valid_o, 1 + extra);
    chk("ar_addr", {64'd0, ar_addr_o}, {64'd0, addr[63:4], 4'h0});
    chk("ar_len", {120'd0, ar_len_o}, 128'd1);
    chk("ar_size", {125'd0, ar_size_o}, 128'd3);
    chk("aw_idle_in_read", {127'd0, aw_valid_o}, 128'd0);
    ar_ready_i = (ar_stall == 0);
    for (int i = 1; i <= ar_stall; i++) begin
      @(negedge clk);
      chk("ar_valid_held", {127'd0, ar_valid_o}, 128'd1);
      chk("ar_addr_held", {64'd0, ar_addr_o}, {64'd0, addr[63:4], 4'h0});
      if (i == ar_stall) ar_ready_i = 1'b1;
    end
    @(negedge clk);
    ar_ready_i = 1'b0;
    chk("ar_valid_drop", {127'd0, ar_valid_o}, 128'd0);
    chk("r_ready", {127'd0, r_ready_o}, 128'd1);
    r_valid_i = 1'b1; r_data_i = b0; r_resp_i = resp0; r_last_i = last0;
    @(negedge clk);
    r_data_i = b1; r_resp_i = resp1; r_last_i = last1;
    @(negedge clk);
    r_valid_i = 1'b0; r_resp_i = 2'b00; r_last_i = 1'b0;
    if (hold) d_rw_addr_i = next_addr;
    else d_rw_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [127:0] line, input int stall,
                          input logic [1:0] bresp, input logic exp_err);
    exp_t e;
    e.data = exp_rd_line;
    e.err  = exp_err;
    e.cyc  = cyc + 5 + stall;
    sb.push_back(e);
    d_rw_addr_i   = addr;
    d_rw_req_i    = 1'b1;
    d_rw_w_data_i = line;
    d_rw_valid_i  = 1'b1;
    wait_for("aw", aw_valid_o, 1);
    chk("aw_addr", {64'd0, aw_addr_o}, {64'd0, addr[63:4], 4'h0});
    chk("aw_len", {120'd0, aw_len_o}, 128'd1);
    chk("aw_size", {125'd0, aw_size_o}, 128'd3);
    chk("ar_idle_in_write", {127'd0, ar_valid_o}, 128'd0);
    aw_ready_i = 1'b1;
    @(negedge clk);
    aw_ready_i = 1'b0;
    chk("w_valid0", {127'd0, w_valid_o}, 128'd1);
    chk("w_data0", {64'd0, w_data_o}, {64'd0, line[63:0]});
    chk("w_last0", {127'd0, w_last_o}, 128'd0);
    chk("w_strb", {120'd0, w_strb_o}, 128'hFF);
    w_ready_i = (stall == 0);
    for (int i = 1; i <= stall; i++) begin
      @(negedge clk);
      chk("w_valid_held", {127'd0, w_valid_o}, 128'd1);
      chk("w_data_held", {64'd0, w_data_o}, {64'd0, line[63:0]});
      chk("w_last_held", {127'd0, w_last_o}, 128'd0);
      if (i == stall) w_ready_i = 1'b1;
    end
    @(negedge clk);
    chk("w_valid1", {127'd0, w_valid_o}, 128'd1);
    chk("w_data1", {64'd0, w_data_o}, {64'd0, line[127:64]});
    chk("w_last1", {127'd0, w_last_o}, 128'd1);
    @(negedge clk);
    w_ready_i = 1'b0;
    chk("w_valid_drop", {127'd0, w_valid_o}, 128'd0);
    chk("b_ready", {127'd0, b_ready_o}, 128'd1);
    b_valid_i = 1'b1; b_resp_i = bresp;
    @(negedge clk);
    b_valid_i = 1'b0; b_resp_i = 2'b00;
    d_rw_valid_i = 1'b0;
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_ar_valid"}, {127'd0, ar_valid_o}, 128'd0);
    chk({tag, "_r_ready"}, {127'd0, r_ready_o}, 128'd0);
    chk({tag, "_aw_valid"}, {127'd0, aw_valid_o}, 128'd0);
    chk({tag, "_w_valid"}, {127'd0, w_valid_o}, 128'd0);
    chk({tag, "_b_ready"}, {127'd0, b_ready_o}, 128'd0);
    chk({tag, "_ready"}, {127'd0, d_rw_ready_o}, 128'd0);
    chk({tag, "_err"}, {127'd0, d_rw_err_o}, 128'd0);
    chk({tag, "_data"}, d_data_read_o, 128'd0);
    chk({tag, "_ar_addr"}, {64'd0, ar_addr_o}, 128'd0);
  endtask

  initial begin
    rst = 1'b0;
    d_rw_addr_i = '0; d_rw_req_i = 1'b0; d_rw_valid_i = 1'b0; d_rw_w_data_i = '0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; b_resp_i = 2'b00;
    repeat (3) @(negedge clk);
    chk_all_idle("reset");
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read with unaligned address.
    do_read(64'h8000_1238, 64'h1111111111111111, 64'h2222222222222222,
            2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 64'd0);
    @(negedge clk);
    // Write with beat 0 stalled three cycles; read data must hold.
    do_write(64'h8000_2048, {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB}, 3, 2'b00, 1'b0);
    @(negedge clk);
    do_write(64'h0000_0010, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}, 0, 2'b11, 1'b1);
    @(negedge clk);
    // Error response on beat 0, then a clean read with a stalled address phase.
    do_read(64'h0000_0100, 64'h3333333333333333, 64'h4444444444444444,
            2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 64'd0);
    @(negedge clk);
    do_read(64'h0000_0204, 64'h5555555555555555, 64'h6666666666666666,
            2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 64'd0);
    @(negedge clk);
    // Early last flag, then missing last flag.
    do_read(64'h0000_0300, 64'h7777777777777777, 64'h8888888888888888,
            2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 64'd0);
    @(negedge clk);
    do_read(64'h0000_0400, 64'h9999999999999999, 64'hCCCCCCCCCCCCCCCC,
            2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 64'd0);
    @(negedge clk);

    // Reset after read beat 0: transaction abandoned without a pulse.
    d_rw_addr_i = 64'h0000_0500; d_rw_req_i = 1'b0; d_rw_valid_i = 1'b1;
    ar_ready_i = 1'b1;
    wait_for("ar_rst", ar_valid_o, 1);
    @(negedge clk);
    ar_ready_i = 1'b0;
    r_valid_i = 1'b1; r_data_i = 64'hDEADBEEFDEADBEEF; r_resp_i = 2'b00; r_last_i = 1'b0;
    @(negedge clk);
    r_valid_i = 1'b0; d_rw_valid_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk_all_idle("midreset");
    exp_rd_line = '0;
    rst = 1'b1;
    @(negedge clk);
    do_read(64'h0000_0600, 64'h0A0A0A0A0A0A0A0A, 64'h0B0B0B0B0B0B0B0B,
            2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 64'd0);
    @(negedge clk);

    // Request held across DONE with a new address: one pulse each, second AR after re-accept.
    do_read(64'h0000_0700, 64'h1010101010101010, 64'h2020202020202020,
            2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 64'h0000_0810);
    do_read(64'h0000_0810, 64'h3030303030303030, 64'h4040404040404040,
            2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 64'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
